// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: command encodings,
// FSM state type and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdOp_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdState_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter that times an in-flight md op; done is asserted
// while the count sits at zero.
module md_lat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for the E stage.
// Optional feature: define MDU_ABORT_EN to add the abort port.
module md_unit_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MDU_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Full {hi,lo} result; the result is computed at accept time and parked.
  function automatic logic [63:0] mdResult(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] da;
    logic signed [31:0] db;
    logic [63:0]        res;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    da  = a;
    db  = b;
    res = '0;
    case (op)
      MD_MULT:  res = sa * sb;
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        // The only signed overflow case wraps to the dividend with zero remainder.
        if (b == 32'd0)                                  res = '0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else                                             res = {32'(da % db), 32'(da / db)};
      end
      MD_DIVU:  res = (b == 32'd0) ? 64'd0 : {a % b, a / b};
      default:  res = '0;
    endcase
    return res;
  endfunction

  mdState_e         state;
  mdState_e         nextState;
  logic             cntLoad;
  logic [CNT_W-1:0] cntLoadVal;
  logic [CNT_W-1:0] cntVal;
  logic             cntDone;
  logic             pendLoad;
  logic             pendWrNext;
  logic             commit;
  logic             hiWrMt;
  logic             loWrMt;
  logic             abortReq;
  logic [31:0]      pendHi;
  logic [31:0]      pendLo;
  logic             pendWr;

`ifdef MDU_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  md_lat_counter #(.WIDTH(CNT_W)) uLatCnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cntLoad),
    .loadVal (cntLoadVal),
    .dec     (state == RUN),
    .count   (cntVal),
    .done    (cntDone)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState  = state;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    pendLoad   = 1'b0;
    pendWrNext = 1'b0;
    commit     = 1'b0;
    hiWrMt     = 1'b0;
    loWrMt     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abortReq) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              cntLoad    = 1'b1;
              cntLoadVal = CNT_W'(MULT_CYCLES - 1);
              pendLoad   = 1'b1;
              pendWrNext = 1'b1;
              nextState  = RUN;
            end
            MD_DIV, MD_DIVU: begin
              cntLoad    = 1'b1;
              cntLoadVal = CNT_W'(DIV_CYCLES - 1);
              pendLoad   = 1'b1;
              pendWrNext = (rt_val != 32'd0);
              nextState  = RUN;
            end
            MD_MTHI: hiWrMt = 1'b1;
            MD_MTLO: loWrMt = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Abort wins over a completion landing on the same edge.
        if (abortReq) begin
          nextState = IDLE;
        end else if (cntDone) begin
          nextState = IDLE;
          commit    = pendWr;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendHi <= '0;
      pendLo <= '0;
      pendWr <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (pendLoad) begin
        {pendHi, pendLo} <= mdResult(md_op, rs_val, rt_val);
        pendWr           <= pendWrNext;
      end
      if (commit) begin
        hi <= pendHi;
        lo <= pendLo;
      end
      if (hiWrMt) hi <= rs_val;
      if (loWrMt) lo <= rs_val;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl; the abort scenario is built only when
// MDU_ABORT_EN is defined.
module tb_md_unit_ctrl;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] rsVal;
  logic [31:0] rtVal;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        abort;

  int tests;
  int fails;
  int n;
  bit held;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (mdOp),
    .rs_val (rsVal),
    .rt_val (rtVal),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
`ifdef MDU_ABORT_EN
    ,
    .abort  (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A command arriving while an op is in flight must never happen.
  always @(posedge clk) begin
    if (reset === 1'b1 && busy === 1'b1 && start === 1'b1) begin
      fails++;
      $error("FAIL start_while_busy observed start=1 required start=0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mdOp  = op;
    rsVal = a;
    rtVal = b;
    @(negedge clk);
    start = 1'b0;
    rsVal = '0;
    rtVal = '0;
  endtask

  task automatic waitIdle(output int cnt, output bit keep,
                          input logic [31:0] oldHi, input logic [31:0] oldLo);
    cnt  = 0;
    keep = 1'b1;
    while (busy === 1'b1 && cnt < 50) begin
      if (hi !== oldHi || lo !== oldLo) keep = 1'b0;
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    start = 1'b0;
    mdOp  = '0;
    rsVal = '0;
    rtVal = '0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    waitIdle(n, held, 32'd0, 32'd0);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitIdle(n, held, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    chk("multu_busy_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle(n, held, 32'h0000_0001, 32'hFFFF_FFFE);
    chk("div_busy_cycles", 32'(n), 32'd10);
    chk("div_hilo_held", {31'd0, held}, 32'd1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_lo_kept", lo, 32'hFFFF_FFFD);

    issue(MD_MTHI, 32'h0000_000A, 32'd0);
    issue(MD_MTLO, 32'h0000_000B, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_000B);
    issue(MD_DIVU, 32'd5, 32'd0);
    waitIdle(n, held, 32'h0000_000A, 32'h0000_000B);
    chk("divu0_busy_cycles", 32'(n), 32'd10);
    chk("divu0_hi", hi, 32'h0000_000A);
    chk("divu0_lo", lo, 32'h0000_000B);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(n, held, 32'h0000_000A, 32'h0000_000B);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);

    issue(MD_DIVU, 32'd100, 32'd7);
    waitIdle(n, held, 32'h0000_0000, 32'h8000_0000);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    waitIdle(n, held, 32'd2, 32'd14);
    chk("div_negdvs_lo", lo, 32'hFFFF_FFFD);
    chk("div_negdvs_hi", hi, 32'd1);

    issue(MD_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    waitIdle(n, held, 32'd1, 32'hFFFF_FFFD);
    chk("mult_neg_hi", hi, 32'd0);
    chk("mult_neg_lo", lo, 32'd12);

    issue(3'd7, 32'h0000_DEAD, 32'd3);
    chk("undef_busy", {31'd0, busy}, 32'd0);
    chk("undef_hi", hi, 32'd0);
    chk("undef_lo", lo, 32'd12);

    issue(MD_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef MDU_ABORT_EN
    issue(MD_MTHI, 32'h55, 32'd0);
    issue(MD_MTLO, 32'h66, 32'd0);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'h55);
    chk("abort_lo", lo, 32'h66);
    issue(MD_MULT, 32'd3, 32'd4);
    waitIdle(n, held, 32'h55, 32'h66);
    chk("post_abort_cycles", 32'(n), 32'd5);
    chk("post_abort_lo", lo, 32'd12);
    chk("post_abort_hi", hi, 32'd0);
    abort = 1'b1;
    issue(MD_MTHI, 32'h77, 32'd0);
    abort = 1'b0;
    chk("abort_mthi_hi", hi, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
